// File: rtl/m_data_mem_mmio_pkg.sv
// Shared definitions for the data-side memory subsystem.
// Contents: MMIO register offsets, STATUS bit positions, default window base,
// address-decode select type and the occupancy display helper.
package m_data_mem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  // Register offsets inside the MMIO window
  localparam logic [31:0] OFS_CYCLE  = 32'h0;
  localparam logic [31:0] OFS_TXDATA = 32'h4;
  localparam logic [31:0] OFS_STATUS = 32'h8;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 7;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  // Occupancy shown in STATUS is a 4-bit field; deeper FIFOs pin at 15.
  function automatic logic [3:0] cnt_sat4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/m_data_mem_mmio_sync_fifo.sv
// Synchronous FIFO used as the MMIO output queue.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  write request and data; refused when full unless a pop
//                   frees the slot in the same cycle
//   i_pop           read request; ignored when empty
//   o_data          head word (don't-care while empty)
//   o_full, o_empty status flags
//   o_count         occupancy, log2(DEPTH)+1 bits
module m_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/m_data_mem_mmio.sv
// Data-side memory subsystem behind the CPU data port: word RAM plus an MMIO
// window (CYCLE counter, TXDATA output FIFO, STATUS/overflow).
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_we, i_addr,    CPU store enable, byte address, store data
//   i_wdata
//   o_rdata          combinational load data
//   o_out_data,      FIFO head word and non-empty flag
//   o_out_valid
//   i_out_ready      consumer takes the head word this cycle
//   o_overflow       sticky: a push to the full FIFO was dropped
module m_data_mem_mmio
  import m_data_mem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_overflow
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] A_CYCLE  = MMIO_BASE + OFS_CYCLE;
  localparam logic [31:0] A_TXDATA = MMIO_BASE + OFS_TXDATA;
  localparam logic [31:0] A_STATUS = MMIO_BASE + OFS_STATUS;

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_addr_lsbs;

  // Byte-lane bits carry no meaning: every access is a full word.
  assign unused_addr_lsbs = ^i_addr[1:0];
  assign ram_idx          = i_addr[AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (i_addr[31:AW+2] == '0)                sel = SEL_RAM;
    else if (i_addr[31:2] == A_CYCLE[31:2])   sel = SEL_CYCLE;
    else if (i_addr[31:2] == A_TXDATA[31:2])  sel = SEL_TXDATA;
    else if (i_addr[31:2] == A_STATUS[31:2])  sel = SEL_STATUS;
  end

  // RAM: combinational read, write on the edge, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we && sel == SEL_RAM) ram_q[ram_idx] <= i_wdata;
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  assign cycle_d = cycle_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) cycle_q <= '0;
    else         cycle_q <= cycle_d;
  end

  // Output FIFO
  assign fifo_push   = i_we && (sel == SEL_TXDATA);
  assign fifo_pop    = o_out_valid && i_out_ready;
  assign o_out_valid = !fifo_empty;

  m_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  (i_wdata),
    .i_pop   (fifo_pop),
    .o_data  (o_out_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Overflow: a dropped push sets it and overrides a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (i_we && sel == SEL_STATUS)             ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;

  always_comb begin
    status                        = '0;
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_OVF]                = ovf_q;
    status[ST_CNT_MSB:ST_CNT_LSB] = cnt_sat4(32'(fifo_count));
  end

  always_comb begin
    o_rdata = '0;
    case (sel)
      SEL_RAM:    o_rdata = ram_q[ram_idx];
      SEL_CYCLE:  o_rdata = cycle_q;
      SEL_STATUS: o_rdata = status;
      default:    o_rdata = '0;
    endcase
  end

endmodule
